// File: rtl/nbuf_pkg.sv
// Shared types and width helpers for the neuron buffer controller and swapper bench.
package nbuf_pkg;

  localparam int unsigned NbufA     = 7;
  localparam int unsigned NbufDepth = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    SWAP  = 2'd3
  } nbuf_state_t;

  // Counters need one extra bit so a full 2^A pass length is representable.
  function automatic int unsigned cntWidth(input int unsigned addrW);
    return addrW + 1;
  endfunction

endpackage

// File: rtl/nbuf_addr_counter.sv
// Bounded address counter: clears on a new pass, advances on enable, flags its terminal count.
module nbuf_addr_counter #(
  parameter int unsigned W = 8
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         clear,
  input  logic         en,
  input  logic [W-1:0] limit,
  output logic [W-2:0] addr,
  output logic         below_c,
  output logic         termHit_c
);

  logic [W-1:0] count;

  always_ff @(posedge CLK) begin
    if (RST) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (en) begin
      count <= count + W'(1);
    end
  end

  // The top bit only matters for the compares; the address wraps past 2^(W-1).
  assign addr      = count[W-2:0];
  assign below_c   = count < limit;
  assign termHit_c = (count + W'(en)) == limit;

endmodule

// File: rtl/neuron_buffer_ctrl.sv
// Per-layer read/write address sequencer and ping-pong select for the neuron buffer swapper.
// Optional protocol checking on err is built when NBUF_CTRL_ERR_CHECK_EN is defined.
module neuron_buffer_ctrl
  import nbuf_pkg::*;
#(
  parameter int unsigned A     = NbufA,
  parameter int unsigned depth = NbufDepth
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         start,
  input  logic [A:0]   readLen,
  input  logic [A:0]   writeLen,
  input  logic         rdReady,
  input  logic         wrValid,
  output logic         rdEn,
  output logic         wrEn,
  output logic [A-1:0] readBuffAddress,
  output logic [A-1:0] writeBuffAddress,
  output logic         readBufferSelect,
  output logic         busy,
  output logic         done,
  output logic         err
);

  localparam int unsigned CntW = cntWidth(A);

  if (depth > A) begin : gDepthCheck
    $error("neuron_buffer_ctrl: depth must not exceed A");
  end

  nbuf_state_t     state;
  nbuf_state_t     nextState;
  logic [CntW-1:0] readLenQ;
  logic [CntW-1:0] writeLenQ;
  logic            startAcc_c;
  logic            rdBelow_c;
  logic            wrBelow_c;
  logic            rdTerm_c;
  logic            wrTerm_c;

  assign startAcc_c = (state == IDLE) && start;
  assign rdEn       = (state == RUN) && rdReady && rdBelow_c;
  assign wrEn       = ((state == RUN) || (state == DRAIN)) && wrValid && wrBelow_c;
  assign busy       = state != IDLE;
  assign done       = state == SWAP;

  nbuf_addr_counter #(.W(CntW)) uRdCnt (
    .CLK       (CLK),
    .RST       (RST),
    .clear     (startAcc_c),
    .en        (rdEn),
    .limit     (readLenQ),
    .addr      (readBuffAddress),
    .below_c   (rdBelow_c),
    .termHit_c (rdTerm_c)
  );

  nbuf_addr_counter #(.W(CntW)) uWrCnt (
    .CLK       (CLK),
    .RST       (RST),
    .clear     (startAcc_c),
    .en        (wrEn),
    .limit     (writeLenQ),
    .addr      (writeBuffAddress),
    .below_c   (wrBelow_c),
    .termHit_c (wrTerm_c)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state            <= IDLE;
      readLenQ         <= '0;
      writeLenQ        <= '0;
      readBufferSelect <= 1'b0;
    end else begin
      state <= nextState;
      if (startAcc_c) begin
        readLenQ  <= readLen;
        writeLenQ <= writeLen;
      end
      // Freshly written buffer becomes the next layer's input.
      if (state == SWAP) begin
        readBufferSelect <= ~readBufferSelect;
      end
    end
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (startAcc_c) nextState = RUN;
      RUN:     if (rdTerm_c)   nextState = DRAIN;
      DRAIN:   if (wrTerm_c)   nextState = SWAP;
      SWAP:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

`ifdef NBUF_CTRL_ERR_CHECK_EN
  logic errHit_c;

  // Sticky: start while busy, stray wrValid outside the write window, or past writeLen.
  assign errHit_c = (start && (state != IDLE))
                 || (wrValid && ((state == IDLE) || (state == SWAP)))
                 || (wrValid && ((state == RUN) || (state == DRAIN)) && !wrBelow_c);

  always_ff @(posedge CLK) begin
    if (RST) begin
      err <= 1'b0;
    end else if (errHit_c) begin
      err <= 1'b1;
    end
  end
`else
  assign err = 1'b0;
`endif

endmodule
